// File: rtl/async_req_arbiter_if.sv
// Handshake bundle between requesters/resource (master) and the arbiter (slave).
// Signals: 4-phase req/ack per requester, one-hot grant, completion and timeout.
interface async_req_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0] req_async;
  logic [N_REQ-1:0] ack;
  logic [N_REQ-1:0] gnt;
  logic             gnt_valid;
  logic [ID_W-1:0]  gnt_id;
  logic             res_done;
  logic             timeout_err;

  modport master (
    output req_async,
    output res_done,
    input  ack,
    input  gnt,
    input  gnt_valid,
    input  gnt_id,
    input  timeout_err
  );

  modport slave (
    input  req_async,
    input  res_done,
    output ack,
    output gnt,
    output gnt_valid,
    output gnt_id,
    output timeout_err
  );
endinterface

// File: rtl/async_req_arbiter.sv
// Round-robin arbiter for asynchronous 4-phase requesters sharing one resource.
// Define ASYNC_ARB_TIMEOUT_EN to compile in the MAX_HOLD grant timeout.
module async_req_arbiter #(
  parameter int N_REQ       = 4,
  parameter int SYNC_STAGES = 3,
  parameter int MAX_HOLD    = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  async_req_arbiter_if.slave   bus
);
  localparam int ID_W = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    ACK
  } state_t;

  logic [N_REQ-1:0] w_req_s;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] r_chain;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_chain <= '0;
        end else begin
          r_chain <= {r_chain[SYNC_STAGES-2:0], bus.req_async[gi]};
        end
      end
      assign w_req_s[gi] = r_chain[SYNC_STAGES-1];
    end
  endgenerate

  state_t           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic             r_gnt_valid;
  logic [ID_W-1:0]  r_gnt_id;
  logic [ID_W-1:0]  r_cur_id;
  logic [N_REQ-1:0] r_ack;
  logic [ID_W-1:0]  r_rr_ptr;

  // Search starts at r_rr_ptr and wraps past N_REQ-1 back to 0.
  logic            w_any;
  logic [ID_W-1:0] w_pick;
  logic [ID_W:0]   w_idx;
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(i);
      if (w_idx >= (ID_W+1)'(N_REQ)) begin
        w_idx = w_idx - (ID_W+1)'(N_REQ);
      end
      if (!w_any && w_req_s[w_idx[ID_W-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_idx[ID_W-1:0];
      end
    end
  end

  logic [ID_W-1:0] w_next_ptr;
  assign w_next_ptr = (r_cur_id == ID_W'(N_REQ-1)) ? '0 : r_cur_id + 1'b1;

`ifdef ASYNC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  logic [CNT_W-1:0] r_hold_cnt;
  logic             r_timeout_err;
  logic             w_hold_hit;
  logic             w_end;
  assign w_hold_hit      = (r_hold_cnt == CNT_W'(MAX_HOLD - 1));
  assign w_end           = bus.res_done | w_hold_hit;
  assign bus.timeout_err = r_timeout_err;
`else
  logic w_end;
  logic w_unused_max_hold;
  assign w_end             = bus.res_done;
  assign bus.timeout_err   = 1'b0;
  // MAX_HOLD only matters when the timeout is compiled in.
  assign w_unused_max_hold = (MAX_HOLD > 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
      r_cur_id    <= '0;
      r_ack       <= '0;
      r_rr_ptr    <= '0;
`ifdef ASYNC_ARB_TIMEOUT_EN
      r_hold_cnt    <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
`ifdef ASYNC_ARB_TIMEOUT_EN
      r_timeout_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt       <= ONE_HOT0 << w_pick;
            r_gnt_valid <= 1'b1;
            r_gnt_id    <= w_pick;
            r_cur_id    <= w_pick;
            r_state     <= GRANT;
`ifdef ASYNC_ARB_TIMEOUT_EN
            r_hold_cnt  <= '0;
`endif
          end
        end
        GRANT: begin
`ifdef ASYNC_ARB_TIMEOUT_EN
          r_hold_cnt <= r_hold_cnt + 1'b1;
`endif
          // A requester dropping req mid-grant is ignored; only completion ends it.
          if (w_end) begin
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
            r_ack       <= r_gnt;
            r_state     <= ACK;
`ifdef ASYNC_ARB_TIMEOUT_EN
            r_timeout_err <= ~bus.res_done;
`endif
          end
        end
        ACK: begin
          if (!w_req_s[r_cur_id]) begin
            r_ack    <= '0;
            r_rr_ptr <= w_next_ptr;
            r_gnt_id <= '0;
            r_state  <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_valid = r_gnt_valid;
  assign bus.gnt_id    = r_gnt_id;
  assign bus.ack       = r_ack;
endmodule

// File: tb/tb_async_req_arbiter.sv
// Scoreboard bench for async_req_arbiter: expected grant ids are queued as
// requests are driven and checked when each new grant appears.
module tb_async_req_arbiter;
  localparam int N  = 4;
  localparam int SS = 3;
  localparam int MH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  async_req_arbiter_if #(.N_REQ(N)) bus();

  async_req_arbiter #(
    .N_REQ(N),
    .SYNC_STAGES(SS),
    .MAX_HOLD(MH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   exp_q[$];
  logic prev_valid = 1'b0;
  int   mon_exp;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard pop on each new grant, plus exclusivity invariants every cycle.
  always @(negedge clk) begin
    check_val("inv_gnt_onehot", 32'($onehot0(bus.gnt)), 32'd1);
    check_val("inv_ack_onehot", 32'($onehot0(bus.ack)), 32'd1);
    check_val("inv_gnt_ack_excl", 32'(bus.gnt & bus.ack), 32'd0);
    check_val("inv_valid", 32'(bus.gnt_valid), 32'(|bus.gnt));
    if (!bus.gnt_valid) check_val("inv_id_zero", 32'(bus.gnt_id), 32'd0);
    if (bus.gnt_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check_val("gnt_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_exp = exp_q.pop_front();
        check_val("gnt_id", 32'(bus.gnt_id), 32'(mon_exp));
        check_val("gnt_vec", 32'(bus.gnt), 32'(1 << mon_exp));
        $display("grant: id=%0d gnt=%b expected id=%0d", bus.gnt_id, bus.gnt, mon_exp);
      end
    end
    prev_valid = bus.gnt_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    bus.res_done = 1'b1;
    tick();
    bus.res_done = 1'b0;
  endtask

  task automatic wait_gnt(input string tag);
    int n = 0;
    while (!bus.gnt_valid && n < 200) begin
      tick();
      n++;
    end
    check_val(tag, 32'(bus.gnt_valid), 32'd1);
  endtask

  task automatic wait_ack_clear(input string tag);
    int n = 0;
    while (bus.ack != '0 && n < 200) begin
      tick();
      n++;
    end
    check_val(tag, 32'(bus.ack), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int  id;
    logic seen_to;
    logic lost;
    bus.req_async = '0;
    bus.res_done  = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check_val("rst_gnt", 32'(bus.gnt), 32'd0);
    check_val("rst_ack", 32'(bus.ack), 32'd0);
    check_val("rst_valid", 32'(bus.gnt_valid), 32'd0);
    check_val("rst_id", 32'(bus.gnt_id), 32'd0);
    check_val("rst_timeout", 32'(bus.timeout_err), 32'd0);
    rst = 1'b0;

    // Single request: exact synchronizer latency, ack handshake.
    bus.req_async[2] = 1'b1;
    exp_q.push_back(2);
    for (int e = 0; e < SS; e++) begin
      tick();
      check_val("lat_early", 32'(bus.gnt), 32'd0);
    end
    tick();
    check_val("lat_gnt", 32'(bus.gnt), 32'h4);
    check_val("lat_id", 32'(bus.gnt_id), 32'd2);
    check_val("lat_valid", 32'(bus.gnt_valid), 32'd1);
    pulse_done();
    check_val("s_ack", 32'(bus.ack), 32'h4);
    check_val("s_gnt_off", 32'(bus.gnt), 32'd0);
    check_val("s_id_off", 32'(bus.gnt_id), 32'd0);
    pulse_done();
    check_val("done_in_ack", 32'(bus.ack), 32'h4);
    bus.req_async[2] = 1'b0;
    for (int e = 0; e < SS; e++) begin
      tick();
      check_val("ack_hold", 32'(bus.ack), 32'h4);
    end
    tick();
    check_val("ack_clr", 32'(bus.ack), 32'd0);
    pulse_done();
    tick();
    check_val("done_in_idle_gnt", 32'(bus.gnt_valid), 32'd0);
    check_val("done_in_idle_ack", 32'(bus.ack), 32'd0);

    // Round robin with all four requesters held.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_async = 4'hF;
    for (int i = 0; i < 5; i++) exp_q.push_back(i % N);
    for (int i = 0; i < 5; i++) begin
      id = i % N;
      wait_gnt("rr_wait");
      pulse_done();
      check_val("rr_ack", 32'(bus.ack), 32'(1 << id));
      if (i == 4) bus.req_async = '0;
      else        bus.req_async[id] = 1'b0;
      wait_ack_clear("rr_ackclr");
      if (i != 4) bus.req_async[id] = 1'b1;
    end
    repeat (6) tick();
    check_val("rr_idle", 32'(bus.gnt_valid), 32'd0);

    // Reset while ack[3] is high, then restart with 1 and 3 pending.
    bus.req_async[3] = 1'b1;
    exp_q.push_back(3);
    wait_gnt("rm_wait3");
    pulse_done();
    check_val("rm_ack3", 32'(bus.ack), 32'h8);
    bus.req_async[1] = 1'b1;
    tick();
    #2 rst = 1'b1;
    #1;
    check_val("rm_ack_async", 32'(bus.ack), 32'd0);
    check_val("rm_gnt_async", 32'(bus.gnt), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    exp_q.push_back(1);
    for (int e = 0; e < SS; e++) begin
      tick();
      check_val("rm_no_ack", 32'(bus.ack), 32'd0);
    end
    wait_gnt("rm_wait1");
    pulse_done();
    check_val("rm_ack1", 32'(bus.ack), 32'h2);
    exp_q.push_back(3);
    bus.req_async[1] = 1'b0;
    wait_ack_clear("rm_clr1");
    wait_gnt("rm_wait3b");
    pulse_done();
    check_val("rm_ack3b", 32'(bus.ack), 32'h8);
    bus.req_async[3] = 1'b0;
    wait_ack_clear("rm_clr3");

`ifndef ASYNC_ARB_TIMEOUT_EN
    // No timeout: grant held 1000 cycles, requester drops req midway.
    bus.req_async[0] = 1'b1;
    exp_q.push_back(0);
    wait_gnt("hold_wait");
    seen_to = 1'b0;
    lost    = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (c == 500) bus.req_async[0] = 1'b0;
      if (bus.timeout_err) seen_to = 1'b1;
      if (!bus.gnt_valid) lost = 1'b1;
    end
    check_val("hold_lost", 32'(lost), 32'd0);
    check_val("hold_timeout", 32'(seen_to), 32'd0);
    check_val("hold_gnt", 32'(bus.gnt), 32'h1);
    pulse_done();
    check_val("hold_ack", 32'(bus.ack), 32'h1);
    wait_ack_clear("hold_clr");
`else
    // Timeout after MH cycles of grant.
    bus.req_async[1] = 1'b1;
    exp_q.push_back(1);
    wait_gnt("to_wait");
    for (int j = 1; j < MH; j++) begin
      tick();
      check_val("to_early", 32'(bus.timeout_err), 32'd0);
      check_val("to_hold", 32'(bus.gnt), 32'h2);
    end
    tick();
    check_val("to_pulse", 32'(bus.timeout_err), 32'd1);
    check_val("to_ack", 32'(bus.ack), 32'h2);
    check_val("to_gnt_off", 32'(bus.gnt), 32'd0);
    tick();
    check_val("to_pulse_end", 32'(bus.timeout_err), 32'd0);
    bus.req_async[1] = 1'b0;
    wait_ack_clear("to_clr");
    // res_done in the same cycle as the timeout counts as completion.
    bus.req_async[2] = 1'b1;
    exp_q.push_back(2);
    wait_gnt("sc_wait");
    repeat (MH - 1) tick();
    bus.res_done = 1'b1;
    tick();
    bus.res_done = 1'b0;
    check_val("sc_timeout", 32'(bus.timeout_err), 32'd0);
    check_val("sc_ack", 32'(bus.ack), 32'h4);
    bus.req_async[2] = 1'b0;
    wait_ack_clear("sc_clr");
`endif

    repeat (6) tick();
    check_val("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/async_req_arbiter.md
ASYNC_REQ_ARBITER -- requirements
Module: async_req_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 3, synchronizer flops per request line (2..4).
REQ-003 SHALL have parameter MAX_HOLD, default 255, grant timeout in clk cycles (1..65535).
REQ-004 SHALL have port clk  input  1  clock; all logic is in this domain.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_async  input  N_REQ  per-requester 4-phase request, asynchronous to clk.
REQ-007 SHALL have port ack  output  N_REQ  per-requester 4-phase acknowledge, registered.
REQ-008 SHALL have port gnt  output  N_REQ  one-hot grant to the shared resource, registered.
REQ-009 SHALL have port gnt_valid  output  1  high while any gnt bit is high.
REQ-010 SHALL have port gnt_id  output  clog2(N_REQ)  index of the granted requester; 0 when gnt_valid low.
REQ-011 SHALL have port res_done  input  1  single-cycle pulse from the resource: granted transaction complete.
REQ-012 SHALL have port timeout_err  output  1  single-cycle pulse on grant timeout.

Function
REQ-013 SHALL pass each req_async bit through a SYNC_STAGES-deep flop chain, all flops reset to 0; only the chain outputs (req_s) are used.
REQ-014 SHALL implement FSM states IDLE, GRANT, ACK.
REQ-015 IDLE: if any req_s bit is high, SHALL select by round-robin starting at pointer rr_ptr, set gnt one-hot, gnt_valid=1, gnt_id, and go to GRANT on the same edge.
REQ-016 Latency: a req_async bit rising before edge k, with the FSM in IDLE, SHALL yield gnt high after edge k+SYNC_STAGES.
REQ-017 GRANT: on res_done=1, SHALL clear gnt and gnt_valid, set ack[gnt_id]=1, and go to ACK.
REQ-018 ACK: when req_s[gnt_id]=0, SHALL clear ack, set rr_ptr=(gnt_id+1) mod N_REQ, force gnt_id to 0, and return to IDLE.
REQ-019 A new grant SHALL NOT be issued in the same cycle that ack is cleared; the earliest new gnt is on the edge after the return to IDLE.
REQ-020 At most one gnt bit and at most one ack bit SHALL be high in any cycle; gnt and ack SHALL never be high together.
REQ-021 res_done in IDLE or ACK SHALL be ignored.
REQ-022 req_s[gnt_id] falling during GRANT (a protocol violation) SHALL NOT end the grant; the grant ends only on res_done or timeout.
REQ-023 Requests from non-granted requesters SHALL be held pending, with no loss, until served.
REQ-024 The round-robin search SHALL wrap from index N_REQ-1 to 0.

Reset
REQ-025 rst high SHALL immediately clear gnt, gnt_valid, gnt_id, ack, timeout_err, rr_ptr, the hold counter, and all synchronizer flops, and set the FSM to IDLE.
REQ-026 Reset asserted mid-GRANT or mid-ACK SHALL abandon the transaction; no ack SHALL be issued for it after reset.
REQ-027 After rst falls, the first grant SHALL go to the lowest-index pending requester.

Configuration
REQ-028 With ASYNC_ARB_TIMEOUT_EN defined, a hold counter SHALL clear on entry to GRANT and increment each cycle in GRANT.
REQ-029 With ASYNC_ARB_TIMEOUT_EN defined, when the hold counter reaches MAX_HOLD without res_done, the block SHALL pulse timeout_err for 1 cycle and take the REQ-017 transition.
REQ-030 With ASYNC_ARB_TIMEOUT_EN defined, res_done and the timeout in the same cycle SHALL be treated as completion, with timeout_err=0.
REQ-031 Without ASYNC_ARB_TIMEOUT_EN, GRANT SHALL wait indefinitely for res_done, timeout_err SHALL be constant 0, and no counter logic SHALL exist.

Verification
REQ-032 Single request: SYNC_STAGES=3, raise req_async[2] -> gnt=4'b0100 and gnt_id=2 three edges after the first sampling edge; res_done pulse -> ack[2]=1; drop req -> ack=0 after the sync delay.
REQ-033 Round-robin: hold all 4 requests and complete each grant -> grant order 0,1,2,3,0; no gnt/ack overlap.
REQ-034 Timeout (macro on, MAX_HOLD=8): grant req 1 with no res_done -> timeout_err pulses 8 cycles after grant, then ack[1]=1.
REQ-035 Same-cycle res_done and timeout: timeout_err=0 and ack asserted.
REQ-036 Reset mid-ACK: assert rst while ack[3]=1 -> ack=0, gnt=0; after release with req 1 and req 3 pending -> first grant goes to 1.
REQ-037 Macro off: hold a grant for 1000 cycles -> gnt stays high, timeout_err=0.
